// File: rtl/word_packer_pkg.sv
// word_packer_pkg: shared defaults, FSM state encoding and lane-count width for word_packer
package word_packer_pkg;
   localparam int SIZE_DEF    = 4;
   localparam int RATIO_DEF   = 4;
   localparam int TIMEOUT_DEF = 8;
   localparam int CNT_W       = $clog2(RATIO_DEF);
   typedef enum logic {EMPTY, FILL} state_t;
   function automatic int cnt_w(input int ratio);
      return $clog2(ratio);
   endfunction
endpackage

// File: rtl/pack_timer.sv
// pack_timer: saturating idle counter that flags when a partial group has waited TIMEOUT cycles
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : count this cycle (accumulator partly filled and idle)
//   clear      : restart from zero (handshake or flush), takes priority over enable
//   expired    : count has reached TIMEOUT
module pack_timer import word_packer_pkg::*; #(
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic expired
);
   logic [7:0] cnt;
   assign expired = cnt == 8'(TIMEOUT);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable && !expired) cnt <= cnt + 8'd1;
endmodule

// File: rtl/word_packer.sv
// word_packer: packs RATIO words of SIZE bits into one beat, closing on a full group, in_last or idle timeout
//   clk, rst_n                          : clock, asynchronous active-low reset
//   in_val, in_rdy, in_data, in_last    : word input handshake; in_last closes the current group
//   out_val, out_rdy                    : packed beat handshake
//   out_data, out_mask, out_last        : packed lanes (lane 0 = first word), occupied-lane mask, closed-by-in_last flag
module word_packer import word_packer_pkg::*; #(
   parameter int SIZE    = SIZE_DEF,
   parameter int RATIO   = RATIO_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_val,
   output logic                  in_rdy,
   input  logic [SIZE-1:0]       in_data,
   input  logic                  in_last,
   output logic                  out_val,
   input  logic                  out_rdy,
   output logic [SIZE*RATIO-1:0] out_data,
   output logic [RATIO-1:0]      out_mask,
   output logic                  out_last
);
   localparam int CW = cnt_w(RATIO);
   state_t state, state_nxt;
   logic [CW-1:0] acc_cnt;
   logic [SIZE*RATIO-1:0] acc_data, merged;
   logic [RATIO-1:0] mask_nxt;
   logic [CW:0] lanes;
   logic hs, close, flush, load, expired;
   // the output register is free exactly when it is empty or being drained this cycle
   assign in_rdy = !out_val || out_rdy;
   assign hs     = in_val && in_rdy;
   assign close  = hs && (in_last || acc_cnt == CW'(RATIO - 1));
   // a handshake in the same cycle beats the timeout
   assign flush  = state == FILL && expired && !hs && in_rdy;
   assign load   = close || flush;
   assign lanes  = {1'b0, acc_cnt} + (CW + 1)'(close);
   // unoccupied accumulator lanes are always zero, so merging is a single lane overwrite
   always_comb begin
      merged   = acc_data;
      mask_nxt = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (CW'(i) == acc_cnt) merged[i*SIZE +: SIZE] = in_data;
         mask_nxt[i] = (CW + 1)'(i) < lanes;
      end
   end
   always_comb begin
      state_nxt = load ? EMPTY : hs ? FILL : state;
   end
   pack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (state == FILL && !hs),
      .clear   (hs || flush),
      .expired (expired)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= EMPTY;
         acc_cnt  <= '0;
         acc_data <= '0;
         out_val  <= 1'b0;
         out_data <= '0;
         out_mask <= '0;
         out_last <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            acc_cnt  <= '0;
            acc_data <= '0;
         end else if (hs) begin
            acc_cnt  <= acc_cnt + CW'(1);
            acc_data <= merged;
         end
         if (load) begin
            out_val  <= 1'b1;
            out_data <= close ? merged : acc_data;
            out_mask <= mask_nxt;
            out_last <= close && in_last;
         end else if (out_rdy) out_val <= 1'b0;
      end
endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed self-checking bench for word_packer (SIZE=4, RATIO=4, TIMEOUT=8)
module tb_word_packer;
   import word_packer_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_val = 1'b0, in_rdy, in_last = 1'b0, out_val, out_rdy = 1'b1, out_last;
   logic [3:0] in_data = '0, out_mask;
   logic [15:0] out_data;
   int errs = 0, checks = 0;

   word_packer #(.SIZE(4), .RATIO(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
      .in_last(in_last), .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
      .out_mask(out_mask), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [3:0] d, input logic l);
      in_val = 1'b1; in_data = d; in_last = l;
      step();
      in_val = 1'b0; in_last = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [15:0] d, input logic [3:0] m, input logic l);
      chk({tag, "_val"}, 32'(out_val), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(d));
      chk({tag, "_mask"}, 32'(out_mask), 32'(m));
      chk({tag, "_last"}, 32'(out_last), 32'(l));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      #3;
      chk("rst_out_val", 32'(out_val), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_mask", 32'(out_mask), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_in_rdy", 32'(in_rdy), 1);
      step(); step();
      rst_n = 1'b1;
      // idle EMPTY never flushes
      repeat (12) step();
      chk("empty_no_flush", 32'(out_val), 0);

      // full group back-to-back
      for (int w = 1; w <= 4; w++) begin
         put(4'(w), 1'b0);
         chk("full_lat", 32'(out_val), 32'(w == 4));
      end
      beat("full", 16'h4321, 4'hF, 1'b0);
      step();
      chk("full_drain", 32'(out_val), 0);

      // group closed by in_last
      put(4'h5, 1'b0); put(4'h6, 1'b0); put(4'h7, 1'b1);
      beat("last3", 16'h0765, 4'h7, 1'b1);
      step();
      // in_last on first word from EMPTY
      put(4'hC, 1'b1);
      beat("last1", 16'h000C, 4'h1, 1'b1);
      // full group with in_last on its final word
      put(4'h1, 1'b0); put(4'h2, 1'b0); put(4'h3, 1'b0); put(4'h4, 1'b1);
      beat("last4", 16'h4321, 4'hF, 1'b1);
      step();

      // timeout flush: timer reaches 8 after 8 idle cycles, flush on the next
      put(4'h9, 1'b0);
      repeat (8) step();
      chk("to_early", 32'(out_val), 0);
      step();
      beat("to", 16'h0009, 4'h1, 1'b0);
      chk("to_state", 32'(dut.state), 32'(EMPTY));
      step();
      chk("to_drain", 32'(out_val), 0);

      // backpressure: held beat stays stable, input blocked
      out_rdy = 1'b0;
      for (int w = 1; w <= 4; w++) put(4'(w), 1'b0);
      chk("bp_in_rdy", 32'(in_rdy), 0);
      in_val = 1'b1; in_data = 4'h5;
      for (int k = 0; k < 3; k++) begin
         step();
         beat("bp_hold", 16'h4321, 4'hF, 1'b0);
         chk("bp_blocked", 32'(dut.acc_cnt), 0);
      end
      out_rdy = 1'b1;
      put(4'h5, 1'b0);
      chk("bp_drain1", 32'(out_val), 0);
      put(4'h6, 1'b0); put(4'h7, 1'b0); put(4'h8, 1'b0);
      out_rdy = 1'b0;
      beat("bp_second", 16'h8765, 4'hF, 1'b0);
      step();
      beat("bp_second_hold", 16'h8765, 4'hF, 1'b0);
      out_rdy = 1'b1;
      step();
      chk("bp_drain2", 32'(out_val), 0);

      // handshake coincides with timeout: no flush, timer restarts
      put(4'h1, 1'b0);
      repeat (8) step();
      put(4'hA, 1'b0);
      chk("race_no_flush", 32'(out_val), 0);
      chk("race_cnt", 32'(dut.acc_cnt), 2);
      repeat (8) step();
      chk("race_restart", 32'(out_val), 0);
      step();
      beat("race", 16'h00A1, 4'h3, 1'b0);
      step();

      // reset mid-group discards partial accumulator
      put(4'h1, 1'b0); put(4'h2, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mr_out_val", 32'(out_val), 0);
      chk("mr_cnt", 32'(dut.acc_cnt), 0);
      chk("mr_in_rdy", 32'(in_rdy), 1);
      step();
      rst_n = 1'b1;
      repeat (12) step();
      chk("mr_no_beat", 32'(out_val), 0);
      for (int w = 3; w <= 6; w++) put(4'(w), 1'b0);
      beat("mr_clean", 16'h6543, 4'hF, 1'b0);
      step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
